// File: rtl/sdrc_mp_arb.sv
// Multi-port SDRAM request arbiter: picks one channel request at a time, forwards it to the
// single app port, and routes write/read data beats back using per-direction tag FIFOs.
module sdrc_mp_arb #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned APP_AW = 26,
  parameter int unsigned APP_DW = 32,
  parameter int unsigned APP_BW = 4,
  parameter int unsigned BL     = 9,
  parameter int unsigned TDEPTH = 4
) (
  input  logic                     sdram_clk,
  input  logic                     sdram_resetn,
  input  logic                     cfg_arb_mode,
  input  logic [NCH-1:0]           ch_req,
  input  logic [NCH*APP_AW-1:0]    ch_req_addr,
  input  logic [NCH*BL-1:0]        ch_req_len,
  input  logic [NCH-1:0]           ch_req_wr_n,
  output logic [NCH-1:0]           ch_req_ack,
  input  logic [NCH*APP_DW-1:0]    ch_wr_data,
  input  logic [NCH*APP_BW-1:0]    ch_wr_en_n,
  output logic [NCH-1:0]           ch_wr_next,
  output logic [APP_DW-1:0]        ch_rd_data,
  output logic [NCH-1:0]           ch_rd_valid,
  output logic [NCH-1:0]           ch_last_rd,
  output logic                     app_req,
  output logic [APP_AW-1:0]        app_req_addr,
  output logic [BL-1:0]            app_req_len,
  output logic                     app_req_wr_n,
  input  logic                     app_req_ack,
  output logic [APP_DW-1:0]        app_wr_data,
  output logic [APP_BW-1:0]        app_wr_en_n,
  input  logic                     app_wr_next_req,
  input  logic                     app_last_wr,
  input  logic [APP_DW-1:0]        app_rd_data,
  input  logic                     app_rd_valid,
  input  logic                     app_last_rd,
  output logic                     err_orphan
);

  localparam int unsigned IDX_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned PTR_AW = (TDEPTH > 1) ? $clog2(TDEPTH) : 1;
  localparam int unsigned PTR_W  = PTR_AW + 1;

  typedef enum logic {S_IDLE, S_REQ} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     win_q, win_sel, rr_ptr_q, rr_ptr_d;
  logic [APP_AW-1:0]    addr_q;
  logic [BL-1:0]        len_q;
  logic                 wr_n_q;
  logic                 err_q, err_d;
  logic [NCH-1:0]       elig;
  logic                 found;
  int unsigned          idx;
  logic                 push_rd, push_wr, pop_rd, pop_wr;

  logic [PTR_W-1:0]     rd_wp_q, rd_rp_q, wr_wp_q, wr_rp_q;
  logic [IDX_W-1:0]     rd_mem_q [TDEPTH];
  logic [IDX_W-1:0]     wr_mem_q [TDEPTH];
  logic                 rd_empty, rd_full, wr_empty, wr_full;
  logic [IDX_W-1:0]     rd_head, wr_head;

  assign rd_empty = (rd_wp_q == rd_rp_q);
  assign wr_empty = (wr_wp_q == wr_rp_q);
  assign rd_full  = (rd_wp_q[PTR_W-1] != rd_rp_q[PTR_W-1]) &&
                    (rd_wp_q[PTR_AW-1:0] == rd_rp_q[PTR_AW-1:0]);
  assign wr_full  = (wr_wp_q[PTR_W-1] != wr_rp_q[PTR_W-1]) &&
                    (wr_wp_q[PTR_AW-1:0] == wr_rp_q[PTR_AW-1:0]);
  assign rd_head  = rd_mem_q[rd_rp_q[PTR_AW-1:0]];
  assign wr_head  = wr_mem_q[wr_rp_q[PTR_AW-1:0]];

  // A channel competes only if its direction's tag FIFO has room; scan starts at 0 or rr_ptr.
  always_comb begin
    elig    = '0;
    found   = 1'b0;
    win_sel = '0;
    idx     = 0;
    for (int unsigned i = 0; i < NCH; i++)
      elig[i] = ch_req[i] & (ch_req_wr_n[i] ? ~rd_full : ~wr_full);
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = cfg_arb_mode ? ((32'(rr_ptr_q) + k) % NCH) : k;
      if (!found && elig[IDX_W'(idx)]) begin
        found   = 1'b1;
        win_sel = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge sdram_clk) begin
    if (!sdram_resetn) state_q <= S_IDLE;
    else               state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (found) state_d = S_REQ;
      S_REQ:   if (app_req_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    app_req    = 1'b0;
    ch_req_ack = '0;
    push_rd    = 1'b0;
    push_wr    = 1'b0;
    if (state_q == S_REQ) begin
      app_req = 1'b1;
      if (app_req_ack) begin
        ch_req_ack[win_q] = 1'b1;
        push_rd           = wr_n_q;
        push_wr           = ~wr_n_q;
      end
    end
  end

  assign app_req_addr = addr_q;
  assign app_req_len  = len_q;
  assign app_req_wr_n = wr_n_q;
  assign err_orphan   = err_q;

  // Data routing follows the FIFO heads; beats with no outstanding tag go nowhere.
  always_comb begin
    app_wr_data = '0;
    app_wr_en_n = '1;
    ch_wr_next  = '0;
    ch_rd_valid = '0;
    ch_last_rd  = '0;
    ch_rd_data  = app_rd_data;
    if (!wr_empty) begin
      app_wr_data         = ch_wr_data[wr_head*APP_DW +: APP_DW];
      app_wr_en_n         = ch_wr_en_n[wr_head*APP_BW +: APP_BW];
      ch_wr_next[wr_head] = app_wr_next_req;
    end
    if (!rd_empty) begin
      ch_rd_valid[rd_head] = app_rd_valid;
      ch_last_rd[rd_head]  = app_last_rd;
    end
  end

  assign pop_wr   = app_last_wr & ~wr_empty;
  assign pop_rd   = app_rd_valid & app_last_rd & ~rd_empty;
  assign err_d    = err_q | (app_rd_valid & rd_empty) | (app_last_wr & wr_empty);
  assign rr_ptr_d = (win_q == IDX_W'(NCH - 1)) ? '0 : IDX_W'(win_q + IDX_W'(1));

  always_ff @(posedge sdram_clk) begin
    if (!sdram_resetn) begin
      win_q    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      wr_n_q   <= 1'b1;
      rr_ptr_q <= '0;
      rd_wp_q  <= '0;
      rd_rp_q  <= '0;
      wr_wp_q  <= '0;
      wr_rp_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == S_IDLE && found) begin
        win_q  <= win_sel;
        addr_q <= ch_req_addr[win_sel*APP_AW +: APP_AW];
        len_q  <= ch_req_len[win_sel*BL +: BL];
        wr_n_q <= ch_req_wr_n[win_sel];
      end
      if (push_rd || push_wr) rr_ptr_q <= rr_ptr_d;
      if (push_rd) rd_wp_q <= rd_wp_q + PTR_W'(1);
      if (push_wr) wr_wp_q <= wr_wp_q + PTR_W'(1);
      if (pop_rd)  rd_rp_q <= rd_rp_q + PTR_W'(1);
      if (pop_wr)  wr_rp_q <= wr_rp_q + PTR_W'(1);
      err_q <= err_d;
    end
  end

  // Tag storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge sdram_clk) begin
    if (push_rd) rd_mem_q[rd_wp_q[PTR_AW-1:0]] <= win_q;
    if (push_wr) wr_mem_q[wr_wp_q[PTR_AW-1:0]] <= win_q;
  end

endmodule
